// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues one word-addressed fetch at a time and holds
// the IF/ID register, honouring decode stall and branch/jump redirect.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_inst_q, pend_inst_d;

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic handshake;
  logic redirect;
  logic resp_live;

  // Request depends only on registered state so there is no path from br/stall/imem inputs.
  assign imem_req  = (state_q == S_REQ) && !pend_valid_q;
  assign imem_addr = pc_q;

  assign handshake = imem_req && imem_ready;
  assign redirect  = br && !stall && id_valid_q;
  // A response on the correct path that is not being killed by a redirect this cycle.
  assign resp_live = (state_q == S_WAIT) && imem_rvalid && !redirect;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d = redirect ? S_KILL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = br_addr;
    end else if (resp_live) begin
      pc_d = pc_q + 32'd1;
    end
  end

  // Pending buffer catches a response that arrives while decode is stalled.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_inst_d  = pend_inst_q;
    if (redirect) begin
      pend_valid_d = 1'b0;
    end else if (resp_live && stall) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = pc_q;
      pend_inst_d  = imem_rdata;
    end else if (!stall && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (!stall) begin
      if (redirect) begin
        id_valid_d = 1'b0;
        id_pc_d    = 32'd0;
        id_inst_d  = NOP_INST;
      end else if (pend_valid_q) begin
        id_valid_d = 1'b1;
        id_pc_d    = pend_pc_q;
        id_inst_d  = pend_inst_q;
      end else if (resp_live) begin
        id_valid_d = 1'b1;
        id_pc_d    = pc_q;
        id_inst_d  = imem_rdata;
      end else begin
        id_valid_d = 1'b0;
        id_pc_d    = 32'd0;
        id_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      pend_inst_q  <= 32'd0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'd0;
      id_inst_q    <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_inst_q  <= pend_inst_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: transaction-level fetch model checked every cycle, plus directed
// literal checks; a second instance exercises PC wrap from RESET_PC=32'hFFFF_FFFF.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'd0;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_inst;

  always #5 clk = ~clk;

  stage_if dut (
    .clk(clk), .rst(rst), .stall(stall), .br(br), .br_addr(br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
  );

  stage_if #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .br(1'b0), .br_addr(32'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .id_valid(w_id_valid), .id_pc(w_id_pc), .id_inst(w_id_inst)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          live;
  } fetch_t;

  fetch_t      fq[$];   // fetches accepted by memory, not yet answered
  fetch_t      pq[$];   // answered while decode stalled, not yet presented
  logic [31:0] m_pc;
  bit          m_idv;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;

  task automatic m_bubble();
    m_idv = 0; m_idpc = 32'd0; m_idinst = 32'h0000_0013;
  endtask

  task automatic model_reset();
    fq.delete(); pq.delete();
    m_pc = 32'd0;
    m_bubble();
  endtask

  task automatic model_step();
    bit     req, taken, got;
    fetch_t e, p, n;
    logic [31:0] pc_before;
    if (rst) begin
      model_reset();
      return;
    end
    pc_before = m_pc;
    req   = (fq.size() == 0) && (pq.size() == 0);
    taken = br && !stall && m_idv;
    got   = 0;
    if (imem_rvalid && fq.size() != 0) begin
      e = fq.pop_front();
      e.inst = imem_rdata;
      got = e.live && !taken;
    end
    if (taken) begin
      for (int i = 0; i < fq.size(); i++) fq[i].live = 0;
      pq.delete();
      m_pc = br_addr;
      m_bubble();
    end else begin
      if (got) m_pc = e.pc + 32'd1;
      if (stall) begin
        if (got) pq.push_back(e);
      end else if (pq.size() != 0) begin
        p = pq.pop_front();
        m_idv = 1; m_idpc = p.pc; m_idinst = p.inst;
      end else if (got) begin
        m_idv = 1; m_idpc = e.pc; m_idinst = e.inst;
      end else begin
        m_bubble();
      end
    end
    if (req && imem_ready) begin
      n.pc = pc_before; n.inst = 32'd0; n.live = !taken;
      fq.push_back(n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'((fq.size() == 0) && (pq.size() == 0)));
      if (imem_req) chk("imem_addr", imem_addr, m_pc);
      chk("id_valid", 32'(id_valid), 32'(m_idv));
      chk("id_pc", id_pc, m_idpc);
      chk("id_inst", id_inst, m_idinst);
    end
  end

  // ---------------- memory environment ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    lat = 1;
  int    cyc = 0;

  task automatic tick();
    bit          hs, whs;
    logic [31:0] a, wa;
    mreq_t       r;
    hs  = imem_req && imem_ready && !rst;
    a   = imem_addr;
    whs = w_req && !rst;
    wa  = w_addr;
    @(posedge clk);
    model_step();
    #1;
    if (hs) begin
      r.addr = a; r.due = cyc + lat;
      mq.push_back(r);
    end
    cyc++;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr + 32'h100;
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    w_rvalid = whs;
    w_rdata  = wa + 32'h100;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk_en = 1;
    ticks(3);
    rst = 1'b0;
    cyc = 0;
    // c0: reset state
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_idv", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'h13);
    chk("rst_idpc", id_pc, 32'd0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFF);
    ticks(2);  // c2
    chk("first_idv", 32'(id_valid), 32'd1);
    chk("first_pc", id_pc, 32'd0);
    chk("first_inst", id_inst, 32'h100);
    chk("second_addr", imem_addr, 32'd1);
    chk("wrap_idpc", w_id_pc, 32'hFFFF_FFFF);
    chk("wrap_inst", w_id_inst, 32'h0000_00FF);
    chk("wrap_addr", w_addr, 32'd0);
    tick();    // c3
    chk("gap_idv", 32'(id_valid), 32'd0);
    chk("gap_req", 32'(imem_req), 32'd0);
    tick();    // c4
    chk("pc1_pc", id_pc, 32'd1);
    chk("pc1_inst", id_inst, 32'h101);
    chk("pc2_addr", imem_addr, 32'd2);
    ticks(6);  // c10: stall cycles 10..12, response for pc 5 lands in c11
    chk("pre_stall_pc", id_pc, 32'd4);
    stall = 1'b1;
    ticks(2);  // c12
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_hold", id_pc, 32'd4);
    tick();    // c13
    stall = 1'b0;
    chk("unstall_hold", id_pc, 32'd4);
    tick();    // c14
    chk("pend_pc", id_pc, 32'd5);
    chk("pend_inst", id_inst, 32'h105);
    chk("after_pend_addr", imem_addr, 32'd6);
    tick();    // c15
    chk("after_pend_idv", 32'(id_valid), 32'd0);
    tick();    // c16: accept pc 7 with 2-cycle memory, hold id under stall
    chk("pc6", id_pc, 32'd6);
    stall = 1'b1;
    lat = 2;
    tick();    // c17: redirect while waiting
    stall = 1'b0; br = 1'b1; br_addr = 32'h40;
    chk("br_idv", 32'(id_valid), 32'd1);
    tick();    // c18: killed response returns
    br = 1'b0;
    chk("kill_req", 32'(imem_req), 32'd0);
    chk("kill_idv", 32'(id_valid), 32'd0);
    tick();    // c19
    chk("tgt_req", 32'(imem_req), 32'd1);
    chk("tgt_addr", imem_addr, 32'h40);
    ticks(3);  // c22
    chk("tgt_pc", id_pc, 32'h40);
    chk("tgt_inst", id_inst, 32'h140);
    stall = 1'b1; br = 1'b1; br_addr = 32'h99;
    ticks(2);  // c24
    stall = 1'b0; br = 1'b0;
    chk("brstall_pc", id_pc, 32'h40);
    chk("brstall_idv", 32'(id_valid), 32'd1);
    tick();    // c25
    chk("brstall_next", id_pc, 32'h41);
    chk("brstall_addr", imem_addr, 32'h42);
    stall = 1'b1; imem_ready = 1'b0;
    tick();    // c26
    chk("notready_addr", imem_addr, 32'h42);
    stall = 1'b0; br = 1'b1; br_addr = 32'h80;
    tick();    // c27
    br = 1'b0;
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h80);
    tick();    // c28
    chk("redir_stable", imem_addr, 32'h80);
    tick();    // c29
    imem_ready = 1'b1;
    ticks(3);  // c32
    chk("redir_pc", id_pc, 32'h80);
    chk("redir_inst", id_inst, 32'h180);
    lat = 3;
    tick();    // c33: reset while the fetch of 0x81 is outstanding
    rst = 1'b1; imem_ready = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_idv", 32'(id_valid), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    tick();    // c34
    rst = 1'b0;
    ticks(2);  // c36: stale response arrived in c35
    chk("stale_idv", 32'(id_valid), 32'd0);
    chk("stale_addr", imem_addr, 32'd0);
    imem_ready = 1'b1; lat = 1;
    ticks(2);  // c38
    chk("post_rst_pc", id_pc, 32'd0);
    chk("post_rst_inst", id_inst, 32'h100);
    chk("post_rst_idv", 32'(id_valid), 32'd1);
    ticks(6);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
